// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART transceiver with independent RX and TX state machines.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx.
module uart_txrx #(
   parameter int baud_rate    = 9600,
   parameter int sys_clk_freq = 12000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);

   localparam int CLOCK_DIVIDE = sys_clk_freq / (baud_rate * 4);
   localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

   localparam logic [2:0] RX_IDLE          = 3'd0;
   localparam logic [2:0] RX_CHECK_START   = 3'd1;
   localparam logic [2:0] RX_READ_BITS     = 3'd2;
   localparam logic [2:0] RX_CHECK_STOP    = 3'd3;
   localparam logic [2:0] RX_DELAY_RESTART = 3'd4;

   localparam logic [1:0] TX_IDLE          = 2'd0;
   localparam logic [1:0] TX_SENDING       = 2'd1;
   localparam logic [1:0] TX_DELAY_RESTART = 2'd2;

   logic             rxSample;

   logic [2:0]       rxState_q, rxState_d;
   logic [DIV_W-1:0] rxDiv_q, rxDiv_d;
   logic [2:0]       rxTick_q, rxTick_d;
   logic [2:0]       rxBit_q, rxBit_d;
   logic [7:0]       rxShift_q, rxShift_d;
   logic [7:0]       rxByte_q, rxByte_d;
   logic             received_q, received_d;
   logic             recvError_q, recvError_d;
   logic             rxTickEdge, rxDone;

   logic [1:0]       txState_q, txState_d;
   logic [DIV_W-1:0] txDiv_q, txDiv_d;
   logic [2:0]       txTick_q, txTick_d;
   logic [3:0]       txBit_q, txBit_d;
   logic [7:0]       txShift_q, txShift_d;
   logic             tx_q, tx_d;
   logic             txTickEdge, txDone;

`ifdef UART_RX_SYNC_EN
   logic [1:0] rxSync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rxSync_q <= 2'b11;
      end else begin
         rxSync_q <= {rxSync_q[0], rx};
      end
   end

   assign rxSample = rxSync_q[1];
`else
   assign rxSample = rx;
`endif

   // Each state restarts its own divider and tick countdown on entry,
   // so bit timing is anchored to the detected start edge.
   assign rxTickEdge = (rxDiv_q == DIV_LAST);
   assign rxDone     = rxTickEdge && (rxTick_q == 3'd1);

   always_comb begin
      rxState_d   = rxState_q;
      rxDiv_d     = rxTickEdge ? '0 : rxDiv_q + 1'b1;
      rxTick_d    = rxTickEdge ? rxTick_q - 3'd1 : rxTick_q;
      rxBit_d     = rxBit_q;
      rxShift_d   = rxShift_q;
      rxByte_d    = rxByte_q;
      received_d  = 1'b0;
      recvError_d = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            rxDiv_d  = '0;
            rxTick_d = 3'd2;
            if (!rxSample) begin
               rxState_d = RX_CHECK_START;
            end
         end
         RX_CHECK_START: begin
            if (rxDone) begin
               rxDiv_d  = '0;
               rxTick_d = 3'd4;
               rxBit_d  = 3'd0;
               rxState_d = rxSample ? RX_IDLE : RX_READ_BITS;
            end
         end
         RX_READ_BITS: begin
            if (rxDone) begin
               rxDiv_d   = '0;
               rxTick_d  = 3'd4;
               rxShift_d = {rxSample, rxShift_q[7:1]};
               rxBit_d   = rxBit_q + 3'd1;
               if (rxBit_q == 3'd7) begin
                  rxState_d = RX_CHECK_STOP;
               end
            end
         end
         RX_CHECK_STOP: begin
            if (rxDone) begin
               rxDiv_d  = '0;
               rxTick_d = 3'd2;
               if (rxSample) begin
                  rxByte_d   = rxShift_q;
                  received_d = 1'b1;
               end else begin
                  recvError_d = 1'b1;
               end
               rxState_d = RX_DELAY_RESTART;
            end
         end
         RX_DELAY_RESTART: begin
            if (rxDone) begin
               rxState_d = RX_IDLE;
            end
         end
         default: begin
            rxState_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rxState_q   <= RX_IDLE;
         rxDiv_q     <= '0;
         rxTick_q    <= 3'd2;
         rxBit_q     <= 3'd0;
         rxShift_q   <= 8'h00;
         rxByte_q    <= 8'h00;
         received_q  <= 1'b0;
         recvError_q <= 1'b0;
      end else begin
         rxState_q   <= rxState_d;
         rxDiv_q     <= rxDiv_d;
         rxTick_q    <= rxTick_d;
         rxBit_q     <= rxBit_d;
         rxShift_q   <= rxShift_d;
         rxByte_q    <= rxByte_d;
         received_q  <= received_d;
         recvError_q <= recvError_d;
      end
   end

   // SENDING covers the start bit and 8 data bits; the stop bit is
   // driven for the whole of DELAY_RESTART.
   assign txTickEdge = (txDiv_q == DIV_LAST);
   assign txDone     = txTickEdge && (txTick_q == 3'd1);

   always_comb begin
      txState_d = txState_q;
      txDiv_d   = txTickEdge ? '0 : txDiv_q + 1'b1;
      txTick_d  = txTickEdge ? txTick_q - 3'd1 : txTick_q;
      txBit_d   = txBit_q;
      txShift_d = txShift_q;
      tx_d      = tx_q;
      case (txState_q)
         TX_IDLE: begin
            txDiv_d  = '0;
            txTick_d = 3'd4;
            tx_d     = 1'b1;
            if (transmit) begin
               txState_d = TX_SENDING;
               txShift_d = tx_byte;
               txBit_d   = 4'd0;
               tx_d      = 1'b0;
            end
         end
         TX_SENDING: begin
            if (txDone) begin
               txDiv_d  = '0;
               txTick_d = 3'd4;
               if (txBit_q == 4'd8) begin
                  tx_d      = 1'b1;
                  txState_d = TX_DELAY_RESTART;
               end else begin
                  tx_d      = txShift_q[0];
                  txShift_d = {1'b0, txShift_q[7:1]};
                  txBit_d   = txBit_q + 4'd1;
               end
            end
         end
         TX_DELAY_RESTART: begin
            if (txDone) begin
               txState_d = TX_IDLE;
            end
         end
         default: begin
            txState_d = TX_IDLE;
            tx_d      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         txState_q <= TX_IDLE;
         txDiv_q   <= '0;
         txTick_q  <= 3'd4;
         txBit_q   <= 4'd0;
         txShift_q <= 8'h00;
         tx_q      <= 1'b1;
      end else begin
         txState_q <= txState_d;
         txDiv_q   <= txDiv_d;
         txTick_q  <= txTick_d;
         txBit_q   <= txBit_d;
         txShift_q <= txShift_d;
         tx_q      <= tx_d;
      end
   end

   assign tx              = tx_q;
   assign received        = received_q;
   assign rx_byte         = rxByte_q;
   assign recv_error      = recvError_q;
   assign is_receiving    = (rxState_q != RX_IDLE);
   assign is_transmitting = (txState_q != TX_IDLE);

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: RX vector table, TX/RX scoreboards,
// and hand sequences for TX timing, false start, echo and mid-frame reset.
module tb_uart_txrx;

   // Faster line rate than the board default keeps the run short;
   // bit timing is derived the same way as in the design.
   localparam int SYS_FREQ = 12000000;
   localparam int BAUD     = 115200;
   localparam int CD       = SYS_FREQ / (BAUD * 4);
   localparam int BIT      = CD * 4;
   localparam int GLITCH   = BIT / 4;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       tx;
   logic       transmit;
   logic [7:0] tx_byte;
   logic       received;
   logic [7:0] rx_byte;
   logic       is_receiving;
   logic       is_transmitting;
   logic       recv_error;

   logic       manualReq;
   logic [7:0] manualByte;
   logic       echoEn;
   logic       txMonEn;

   int testCount = 0;
   int failCount = 0;
   int recvCount = 0;
   int errCount  = 0;

   logic [7:0] rxQueue[$];
   logic [7:0] txQueue[$];

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      int         expReceived;
      int         expErrors;
      logic [7:0] expRxByte;
   } rxVec_t;

   rxVec_t vectors[6];

   assign transmit = manualReq | (echoEn & received);
   assign tx_byte  = (echoEn & received) ? rx_byte : manualByte;

   uart_txrx #(
      .baud_rate(BAUD),
      .sys_clk_freq(SYS_FREQ)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .tx(tx),
      .transmit(transmit),
      .tx_byte(tx_byte),
      .received(received),
      .rx_byte(rx_byte),
      .is_receiving(is_receiving),
      .is_transmitting(is_transmitting),
      .recv_error(recv_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #(BIT * 400 * 10);
      $display("[TB] FAIL watchdog: run did not finish, got timeout, wanted completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one 8N1 frame on rx, starting on a falling clock edge.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      logic [9:0] frame;
      frame = {stopBit, data, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (BIT) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   // RX monitor: every received strobe is matched against the scoreboard.
   logic prevReceived = 1'b0;
   logic prevError    = 1'b0;
   logic [7:0] rxExp;

   always @(negedge clk) begin
      if (received === 1'b1) begin
         recvCount++;
         if (rxQueue.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL rx_unexpected: got byte 0x%0h, wanted no strobe", rx_byte);
         end else begin
            rxExp = rxQueue.pop_front();
            checkOutput("rx_byte", rx_byte, rxExp);
         end
         checkOutput("rx_pulse_width", prevReceived, 0);
      end
      if (recv_error === 1'b1) begin
         errCount++;
         checkOutput("err_pulse_width", prevError, 0);
      end
      prevReceived = received;
      prevError    = recv_error;
   end

   // TX monitor: decodes frames at bit centres and checks the scoreboard.
   logic [9:0] txMonBits;
   logic [7:0] txExp;

   always begin
      @(negedge clk);
      if (txMonEn && tx === 1'b0) begin
         repeat (BIT / 2) @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            txMonBits[i] = tx;
            if (i < 9) repeat (BIT) @(negedge clk);
         end
         if (txMonEn) begin
            if (txQueue.size() == 0) begin
               testCount++;
               failCount++;
               $display("[TB] FAIL tx_unexpected: got frame 0x%0h, wanted no frame", txMonBits);
            end else begin
               txExp = txQueue.pop_front();
               checkOutput("tx_frame", txMonBits, {1'b1, txExp, 1'b0});
            end
         end
      end
   end

   logic [9:0] a5Pattern;
   int         cycles;
   int         recvBefore;
   int         errBefore;
   logic       sawBusy;

   initial begin
      rst        = 1'b0;
      rx         = 1'b1;
      manualReq  = 1'b0;
      manualByte = 8'h00;
      echoEn     = 1'b0;
      txMonEn    = 1'b1;
      a5Pattern  = 10'b1101001010;

      vectors[0] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
      vectors[1] = '{8'h3C, 1'b0, 0, 1, 8'h3C};
      vectors[2] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vectors[3] = '{8'h81, 1'b0, 0, 1, 8'hA5};
      vectors[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vectors[5] = '{8'hFF, 1'b0, 0, 1, 8'h00};

      repeat (5) begin
         @(negedge clk);
         checkOutput("reset_state",
                     {tx, received, recv_error, is_receiving, is_transmitting, rx_byte},
                     13'h1000);
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post_reset",
                     {tx, received, recv_error, is_receiving, is_transmitting, rx_byte},
                     13'h1000);
      end

      // TX 0xA5: latency, bit pattern, busy length, mid-frame request ignored.
      manualByte = 8'hA5;
      manualReq  = 1'b1;
      txQueue.push_back(8'hA5);
      @(negedge clk);
      manualReq = 1'b0;
      checkOutput("tx_latency", {tx, is_transmitting}, 2'b01);
      cycles = 0;
      while (is_transmitting === 1'b1 && cycles < 12 * BIT) begin
         cycles++;
         if ((cycles % BIT) == BIT / 2) begin
            checkOutput("tx_a5_bit", tx, a5Pattern[cycles / BIT]);
         end
         manualReq = 1'b0;
         if (cycles == 3 * BIT) begin
            manualByte = 8'h0F;
            manualReq  = 1'b1;
         end
         @(negedge clk);
      end
      manualReq = 1'b0;
      checkOutput("tx_busy_len", cycles, 10 * BIT);
      checkOutput("tx_idle_high", tx, 1'b1);
      repeat (2 * BIT) @(negedge clk);
      checkOutput("tx_busy_ignored", is_transmitting, 1'b0);
      checkOutput("tx_queue_after_a5", txQueue.size(), 0);

      // RX vector table: good frames and framing errors.
      foreach (vectors[v]) begin
         recvBefore = recvCount;
         errBefore  = errCount;
         if (vectors[v].expReceived != 0) rxQueue.push_back(vectors[v].data);
         applyStimulus(vectors[v].data, vectors[v].stopBit);
         repeat (2 * BIT) @(negedge clk);
         checkOutput("rx_vec_received", recvCount - recvBefore, vectors[v].expReceived);
         checkOutput("rx_vec_errors", errCount - errBefore, vectors[v].expErrors);
         checkOutput("rx_vec_byte", rx_byte, vectors[v].expRxByte);
         checkOutput("rx_vec_idle", is_receiving, 1'b0);
      end

      // False start: short low glitch must not produce strobes.
      recvBefore = recvCount;
      errBefore  = errCount;
      sawBusy    = 1'b0;
      rx = 1'b0;
      repeat (GLITCH) begin
         @(negedge clk);
         if (is_receiving === 1'b1) sawBusy = 1'b1;
      end
      rx = 1'b1;
      checkOutput("glitch_rise", sawBusy, 1'b1);
      repeat (BIT) @(negedge clk);
      checkOutput("glitch_idle", is_receiving, 1'b0);
      checkOutput("glitch_strobes", (recvCount - recvBefore) + (errCount - errBefore), 0);
      checkOutput("glitch_byte", rx_byte, 8'hFF & 8'h00);

      // Echo: back-to-back RX frames looped to TX.
      echoEn = 1'b1;
      rxQueue.push_back(8'h00); txQueue.push_back(8'h00);
      rxQueue.push_back(8'hFF); txQueue.push_back(8'hFF);
      rxQueue.push_back(8'h55); txQueue.push_back(8'h55);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h55, 1'b1);
      repeat (12 * BIT) @(negedge clk);
      echoEn = 1'b0;
      checkOutput("echo_rx_queue", rxQueue.size(), 0);
      checkOutput("echo_tx_queue", txQueue.size(), 0);
      checkOutput("echo_last_byte", rx_byte, 8'h55);

      // Reset mid-frame, then reset held together with transmit.
      txMonEn    = 1'b0;
      recvBefore = recvCount;
      manualByte = 8'h00;
      manualReq  = 1'b1;
      @(negedge clk);
      manualReq = 1'b0;
      rx = 1'b0;
      repeat (3 * BIT) @(negedge clk);
      checkOutput("pre_abort_busy", {tx, is_transmitting, is_receiving}, 3'b011);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_state", {tx, is_transmitting, is_receiving}, 3'b100);
      manualReq = 1'b1;
      @(negedge clk);
      checkOutput("reset_wins", {tx, is_transmitting, is_receiving}, 3'b100);
      manualReq = 1'b0;
      rx  = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_rx_byte", rx_byte, 8'h00);
      repeat (2 * BIT) @(negedge clk);
      checkOutput("abort_no_strobe", recvCount - recvBefore, 0);
      checkOutput("abort_idle", {tx, is_transmitting, is_receiving}, 3'b100);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
